// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-port arbiter sequencing one memory bus transaction at a time
module mem_bus_arbiter #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic [WIDTH-1:0] m0_addr,
   input  logic [WIDTH-1:0] m0_wdata,
   input  logic [3:0]       m0_byteen,
   output logic             m0_ready,
   output logic [WIDTH-1:0] m0_rdata,
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic [WIDTH-1:0] m1_addr,
   input  logic [WIDTH-1:0] m1_wdata,
   input  logic [3:0]       m1_byteen,
   output logic             m1_ready,
   output logic [WIDTH-1:0] m1_rdata,
   output logic             bus_mem_read,
   output logic             bus_mem_write,
   output logic [WIDTH-1:0] bus_addr,
   output logic [WIDTH-1:0] bus_wdata,
   output logic [3:0]       bus_byteen,
   input  logic [WIDTH-1:0] bus_rdata,
   output logic             busy,
   output logic             gnt_id
);
   typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic last_grant, gnt, we_q, win, any_req;
   logic [3:0] cnt;
   logic [WIDTH-1:0] addr_q, wdata_q;
   logic [3:0] byteen_q;
   assign any_req = m0_req | m1_req;
   // on a tie the port not granted last wins
   assign win = (m0_req & m1_req) ? ~last_grant : m1_req;
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         gnt        <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         byteen_q   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= state == CMD ? 4'(LATENCY > 1 ? LATENCY - 2 : 0) : state == WAIT ? cnt - 4'd1 : cnt;
         if (state == IDLE && any_req) begin
            gnt        <= win;
            last_grant <= win;
            we_q       <= win ? m1_we : m0_we;
            addr_q     <= win ? m1_addr : m0_addr;
            wdata_q    <= win ? m1_wdata : m0_wdata;
            byteen_q   <= win ? m1_byteen : m0_byteen;
         end
      end
   end
   always_comb begin
      state_nx = state == IDLE ? (any_req ? CMD : IDLE) :
                 state == CMD  ? (LATENCY == 1 ? RESP : WAIT) :
                 state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
   end
   always_comb begin
      busy          = state != IDLE;
      gnt_id        = gnt;
      bus_mem_write = state == CMD && we_q;
      bus_mem_read  = state == CMD && !we_q;
      bus_addr      = busy ? addr_q : '0;
      bus_wdata     = busy ? wdata_q : '0;
      bus_byteen    = busy ? byteen_q : '0;
      m0_ready      = state == RESP && !gnt;
      m1_ready      = state == RESP && gnt;
      m0_rdata      = (m0_ready && !we_q) ? bus_rdata : '0;
      m1_rdata      = (m1_ready && !we_q) ? bus_rdata : '0;
   end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer for the shared `memory_bus`. It sits between two requesters and the single memory bus port:
- port 0: the multicycle core's memory interface;
- port 1: a secondary master such as a program loader or debug port.

It grants one complete transaction at a time with round-robin priority, latches the request, and drives the bus command for one cycle. It returns read data to the granted requester with a one-cycle ready pulse after a fixed bus latency.

## Interface
- `WIDTH`, 32: address and data width.
- `LATENCY`, 1: cycles from the bus command cycle to valid `bus_rdata`; legal range 1–15.

Clock and reset:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.

Requester port `mX`, with X in {0,1}:
- `mX_req`  in  1: transaction request; held high with fields stable until `mX_ready`.
- `mX_we`  in  1: 1 = write, 0 = read.
- `mX_addr`  in  WIDTH: byte address.
- `mX_wdata`  in  WIDTH: write data.
- `mX_byteen`  in  4: byte enables.
- `mX_ready`  out  1: one-cycle completion pulse.
- `mX_rdata`  out  WIDTH: read data, valid only while `mX_ready` is high; otherwise 0.

Bus side:
- `bus_mem_read`  out  1: read strobe.
- `bus_mem_write`  out  1: write strobe.
- `bus_addr`  out  WIDTH: bus address.
- `bus_wdata`  out  WIDTH: bus write data.
- `bus_byteen`  out  4: bus byte enables.
- `bus_rdata`  in  WIDTH: memory read data.

Status:
- `busy`  out  1: high when the state is not IDLE.
- `gnt_id`  out  1: index of the granted port; meaningful only while `busy` is high.

## Operation
- FSM states: IDLE, CMD, WAIT, RESP.

IDLE:
- If either `mX_req` is high, select a winner.
- On a tie, grant the port not granted last. The `last_grant` register resets to 1, so port 0 wins the first tie.
- Latch the winner's we/addr/wdata/byteen and its index into `gnt_id`. Update `last_grant`. Go to CMD.
- If no request is present, stay in IDLE.

CMD (exactly 1 cycle):
- `bus_mem_write` = latched we.
- `bus_mem_read` = !latched we.
- `bus_addr`, `bus_wdata` and `bus_byteen` are driven from the latched registers.
- If `LATENCY`=1, go to RESP. Otherwise load the wait counter with `LATENCY`-2 and go to WAIT.

WAIT:
- Both strobes are low. Address, wdata and byteen keep their latched values.
- Decrement the counter. When the counter is 0, go to RESP.

RESP (1 cycle):
- Addr, wdata and byteen remain latched values; both strobes are low.
- The granted `mX_ready` is 1.
- For reads, the granted `mX_rdata` = `bus_rdata`. For writes, `mX_rdata` = 0.
- Go to IDLE.

Outside CMD/WAIT/RESP:
- Bus address, wdata and byteen are 0; both strobes are low.

Requester rules:
- The arbiter uses only the latched fields. Changing or dropping `mX_req` after the grant does not abort the transaction, and `mX_ready` still pulses.
- A requester keeping `mX_req` high after `mX_ready` presents a new request, arbitrated in the next IDLE cycle.

Other rules:
- Read and write transactions have identical timing.
- Only the granted port ever sees ready or nonzero rdata. The two ready signals are never high together.
- The arbiter does not decode `byteen`; it forwards it unchanged.

## Timing
Reset values (cycle after `reset` sampled high):
- State IDLE, `last_grant`=1, wait counter 0.
- All outputs 0: strobes, bus addr/wdata/byteen, both ready, both rdata, `busy`, `gnt_id`.

Reset during any state:
- The in-flight transaction is dropped with no ready pulse.
- Strobes are low from the next cycle on. Requesters must re-issue.

Per-transaction timing, with the request seen in IDLE at cycle t:
- CMD at t+1.
- RESP/ready at t+1+`LATENCY`.
- IDLE at t+2+`LATENCY`.
- Throughput is one transaction per `LATENCY`+2 cycles.

Other timing rules:
- A request that arrives while `busy` is high waits until IDLE; it is not queued.
- Maximum wait for a continuously requesting port is one foreign transaction (`LATENCY`+2 cycles) plus its own.
- Strobes are high for exactly one cycle per transaction.

## Test plan
- **Write then read, `LATENCY`=1, port 0:** m0 writes 0x100 = 0xDEADBEEF with byteen 0xF.
  - `bus_mem_write` is high only at t+1 and `m0_ready` pulses at t+2.
  - A following read of 0x100 returns 0xDEADBEEF on `m0_rdata` during `m0_ready`.
- **Simultaneous first requests after reset:** m0 and m1 both request in the same cycle. m0 is granted first (`gnt_id`=0), then m1; `m1_ready` arrives 3 cycles after `m0_ready`.
- **Continuous contention:** both ports request 4 back-to-back transactions each.
  - Grant order is 0,1,0,1,0,1,0,1.
  - Ready pulses never overlap.
  - Non-granted rdata stays 0.
- **Partial write:** word 0x200 holds 0x11223344; write 0x0000AB00 with byteen 0b0010. A read of 0x200 returns 0x1122AB44.
- **Reset mid-transaction, `LATENCY`=3:** assert `reset` in the first WAIT cycle of an m1 read.
  - No `m1_ready` pulse.
  - `busy`=0 and all outputs 0 on the next cycle.
  - The next simultaneous request grants m0.
- **Single port streaming, `LATENCY`=2:** m1 holds `m1_req` high for 3 reads.
  - `m1_ready` pulses every 4 cycles.
  - `bus_addr` changes only at CMD cycles.
  - `m0_ready` stays 0 throughout.
